pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Central sequencing controller for the 5-stage (IF/ID/EX/MEM/WB) pipelined core, which has no forwarding paths.
- Keeps a shadow pipeline of in-flight destination-register tags and stalls the ID stage on RAW hazards.
- Drains the pipeline and raises a sticky halt when a halting ecall is issued.
- Keeps cycle, stall and retire counters for the testbench.

Parameters:
WB_BYPASS, 0, 1 = register file is write-before-read, so the WB-stage tag is not a hazard source.
DRAIN_CYCLES, 3, number of bubble cycles after halt acceptance before is_halted asserts; legal range 1..7.
CNT_W, 32, width of the statistics counters.

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
id_valid  input  1  ID stage holds a real instruction (not a bubble)
id_rs1  input  5  rs1 field of the ID instruction
id_rs2  input  5  rs2 field of the ID instruction
id_use_rs1  input  1  ID instruction reads rs1 (an ecall reads x17 through rs1)
id_use_rs2  input  1  ID instruction reads rs2
id_rd  input  5  rd field of the ID instruction
id_reg_write  input  1  ID instruction writes rd
id_is_ecall  input  1  ID instruction is an ecall
id_halt_cond  input  1  halt condition is met (x17 == 10), valid with id_is_ecall
pc_write  output  1  PC may update this cycle
if_id_write  output  1  IF/ID register may load this cycle
id_ex_bubble  output  1  ID/EX loads a bubble (all control bits 0)
is_halted  output  1  sticky halt indication
cycle_cnt  output  CNT_W  cycles spent in RUN or DRAIN
stall_cnt  output  CNT_W  hazard-stall cycles
retire_cnt  output  CNT_W  non-bubble instructions that reached WB

Behaviour:
- State machine with three states: RUN, DRAIN, HALTED.
- Shadow tags: ex, mem and wb stages each hold {inst_v, wr_v, rd}.
- Tag advance on every clock: wb <= mem, mem <= ex.
- ex <= {1, id_reg_write && id_rd != 0, id_rd} when issue = 1; otherwise ex <= all-zero.
- match(r) = r != 0 && ((ex.wr_v && ex.rd == r) || (mem.wr_v && mem.rd == r) || (!WB_BYPASS && wb.wr_v && wb.rd == r)).
- hazard = id_valid && ((id_use_rs1 && match(id_rs1)) || (id_use_rs2 && match(id_rs2))).
- halt_acc = state == RUN && id_valid && id_is_ecall && id_halt_cond && !hazard.
- issue = state == RUN && id_valid && !hazard && !halt_acc.
- RUN, no hazard, no halt_acc: pc_write = 1, if_id_write = 1, id_ex_bubble = 0.
- RUN, hazard: pc_write = 0, if_id_write = 0, id_ex_bubble = 1; stall_cnt increments.
- RUN, halt_acc: outputs as for hazard, but stall_cnt does not increment; next state DRAIN; drain counter loads DRAIN_CYCLES.
- Hazard has priority over halt_acc: an ecall waiting on x17 stalls first, then is accepted.
- An ecall with id_halt_cond = 0 issues as a normal instruction.
- DRAIN: pc_write = 0, if_id_write = 0, id_ex_bubble = 1; drain counter decrements each cycle; when the counter is 1, next state HALTED.
- With ecall accepted in cycle T, DRAIN occupies cycles T+1..T+DRAIN_CYCLES and is_halted = 1 from cycle T+DRAIN_CYCLES+1.
- HALTED: sticky until reset; is_halted = 1; pc_write = 0, if_id_write = 0, id_ex_bubble = 1; tags keep advancing.
- is_halted is registered; it is 1 exactly when state == HALTED.
- cycle_cnt increments in RUN and DRAIN and freezes in HALTED.
- retire_cnt increments when wb.inst_v = 1, including in DRAIN and HALTED.
- All counters saturate at 2^CNT_W - 1; they never wrap.
- id_valid = 0 in RUN: no hazard; pc_write = 1, if_id_write = 1, id_ex_bubble = 1 (ID holds nothing to issue).
- Reset asserted (low), at any time including mid-DRAIN: immediately state = RUN, all tags cleared, counters = 0, is_halted = 0.
- While reset is low, pc_write = 0, if_id_write = 0, id_ex_bubble = 1.
- First issue is possible in the first cycle after reset deasserts.

Test Plan:
1. WB_BYPASS=0: issue rd=5 writer, then id_rs1=5 with id_use_rs1=1 -> pc_write low and id_ex_bubble high for exactly 3 cycles, then issue; stall_cnt = 3.
2. WB_BYPASS=1, same stimulus -> exactly 2 stall cycles; stall_cnt = 2.
3. Writer with rd=0, then reader with rs1=0 and rs2=0 -> no stall; pc_write stays 1.
4. DRAIN_CYCLES=3: writer to x17, then ecall (rs1=17, halt_cond=1) -> 3 stall cycles, accept in cycle T, is_halted = 1 from T+4 and stays high; pc_write = 0 from T onward; retire_cnt = 1; cycle_cnt frozen.
5. Ecall with id_halt_cond=0 -> normal issue; is_halted stays 0; retire_cnt increments 3 cycles later.
6. Reset driven low mid-DRAIN without a clock edge -> is_halted = 0, cycle_cnt = stall_cnt = retire_cnt = 0 immediately; after release, an independent instruction issues in the first cycle.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - ID-stage hazard inputs, pipeline control outputs and statistics of pipe_hazard_ctrl
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             id_valid;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [4:0]       id_rd;
  logic             id_reg_write;
  logic             id_is_ecall;
  logic             id_halt_cond;
  logic             pc_write;
  logic             if_id_write;
  logic             id_ex_bubble;
  logic             is_halted;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] retire_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_reg_write, id_is_ecall, id_halt_cond,
    input  pc_write, if_id_write, id_ex_bubble, is_halted,
           cycle_cnt, stall_cnt, retire_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_reg_write, id_is_ecall, id_halt_cond,
    output pc_write, if_id_write, id_ex_bubble, is_halted,
           cycle_cnt, stall_cnt, retire_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - RAW-hazard stall, halt drain and statistics controller for the 5-stage pipeline
module pipe_hazard_ctrl #(
  parameter bit WB_BYPASS    = 1'b0,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input logic               clk,
  input logic               reset,
  pipe_hazard_ctrl_if.slave bus
);
  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  typedef struct packed {
    logic       inst_v;
    logic       wr_v;
    logic [4:0] rd;
  } tag_t;

  logic [1:0]       state;
  logic [2:0]       drain_cnt;
  tag_t             ex_tag, mem_tag, wb_tag, ex_next;
  logic [CNT_W-1:0] cycle_q, stall_q, retire_q;
  logic             match_rs1, match_rs2, hazard, halt_acc, issue, in_run;

  function automatic logic tag_hit(input tag_t t, input logic [4:0] r);
    return t.wr_v && (t.rd == r);
  endfunction

  always_comb begin
    in_run    = (state == ST_RUN);
    match_rs1 = (bus.id_rs1 != 5'd0) &&
                (tag_hit(ex_tag, bus.id_rs1) || tag_hit(mem_tag, bus.id_rs1) ||
                 (!WB_BYPASS && tag_hit(wb_tag, bus.id_rs1)));
    match_rs2 = (bus.id_rs2 != 5'd0) &&
                (tag_hit(ex_tag, bus.id_rs2) || tag_hit(mem_tag, bus.id_rs2) ||
                 (!WB_BYPASS && tag_hit(wb_tag, bus.id_rs2)));
    hazard    = bus.id_valid && ((bus.id_use_rs1 && match_rs1) || (bus.id_use_rs2 && match_rs2));
    halt_acc  = in_run && bus.id_valid && bus.id_is_ecall && bus.id_halt_cond && !hazard;
    issue     = in_run && bus.id_valid && !hazard && !halt_acc;
    ex_next   = issue ? {1'b1, bus.id_reg_write && (bus.id_rd != 5'd0), bus.id_rd} : '0;
  end

  // Front end only advances in RUN without a stall; an empty ID slot still lets IF refill.
  always_comb begin
    bus.pc_write     = 1'b0;
    bus.if_id_write  = 1'b0;
    bus.id_ex_bubble = 1'b1;
    if (reset && in_run && !hazard && !halt_acc) begin
      bus.pc_write     = 1'b1;
      bus.if_id_write  = 1'b1;
      bus.id_ex_bubble = !bus.id_valid;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_RUN;
      drain_cnt <= '0;
      ex_tag    <= '0;
      mem_tag   <= '0;
      wb_tag    <= '0;
      cycle_q   <= '0;
      stall_q   <= '0;
      retire_q  <= '0;
    end else begin
      wb_tag  <= mem_tag;
      mem_tag <= ex_tag;
      ex_tag  <= ex_next;

      case (state)
        ST_RUN: begin
          if (halt_acc) begin
            state     <= ST_DRAIN;
            drain_cnt <= 3'(DRAIN_CYCLES);
          end
        end
        ST_DRAIN: begin
          drain_cnt <= drain_cnt - 3'd1;
          if (drain_cnt == 3'd1) state <= ST_HALTED;
        end
        default: state <= ST_HALTED;
      endcase

      if (state != ST_HALTED && cycle_q != '1) cycle_q <= cycle_q + 1'b1;
      if (in_run && hazard && stall_q != '1)   stall_q <= stall_q + 1'b1;
      if (wb_tag.inst_v && retire_q != '1)     retire_q <= retire_q + 1'b1;
    end
  end

  assign bus.is_halted  = (state == ST_HALTED);
  assign bus.cycle_cnt  = cycle_q;
  assign bus.stall_cnt  = stall_q;
  assign bus.retire_cnt = retire_q;
endmodule
